// File: rtl/reg_file_wb.sv
// Writeback-stage register file with two bypassed read ports and a per-register
// scoreboard of in-flight writes that drives the decode stall.
module reg_file_wb #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 4,
  parameter bit          ZERO_REG = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_WE_MEM_WB,
  input  logic [DATA_W-1:0] i_WB_Data,
  input  logic [ADDR_W-1:0] i_WB_Dir,
  input  logic [ADDR_W-1:0] i_Rs_Dir,
  input  logic [ADDR_W-1:0] i_Rt_Dir,
  input  logic              i_Issue_EN,
  input  logic [ADDR_W-1:0] i_Issue_Dir,
  input  logic              i_Flush,
  output logic [DATA_W-1:0] o_Rs_Data,
  output logic [DATA_W-1:0] o_Rt_Data,
  output logic              o_Stall,
  output logic              o_Issue_Full
);

  localparam int unsigned NREG = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q [NREG];
  logic [1:0]        pend_q [NREG];
  logic [1:0]        pend_d [NREG];

  logic write_en;
  logic inc, dec, same_reg;
  logic rs_busy, rt_busy;

  assign write_en = i_WE_MEM_WB && !(ZERO_REG && (i_WB_Dir == '0));

  // Read ports: hard zero first, then same-cycle writeback bypass, then storage.
  always_comb begin
    o_Rs_Data = regs_q[i_Rs_Dir];
    if (ZERO_REG && (i_Rs_Dir == '0))
      o_Rs_Data = '0;
    else if (i_WE_MEM_WB && (i_WB_Dir == i_Rs_Dir))
      o_Rs_Data = i_WB_Data;

    o_Rt_Data = regs_q[i_Rt_Dir];
    if (ZERO_REG && (i_Rt_Dir == '0))
      o_Rt_Data = '0;
    else if (i_WE_MEM_WB && (i_WB_Dir == i_Rt_Dir))
      o_Rt_Data = i_WB_Data;
  end

  // A single outstanding write is resolved by a writeback to the same register
  // in this cycle, since the bypass then supplies the value.
  always_comb begin
    rs_busy = (pend_q[i_Rs_Dir] >= 2'd2) ||
              ((pend_q[i_Rs_Dir] == 2'd1) && !(i_WE_MEM_WB && (i_WB_Dir == i_Rs_Dir)));
    if (ZERO_REG && (i_Rs_Dir == '0))
      rs_busy = 1'b0;

    rt_busy = (pend_q[i_Rt_Dir] >= 2'd2) ||
              ((pend_q[i_Rt_Dir] == 2'd1) && !(i_WE_MEM_WB && (i_WB_Dir == i_Rt_Dir)));
    if (ZERO_REG && (i_Rt_Dir == '0))
      rt_busy = 1'b0;
  end

  assign o_Stall      = rs_busy || rt_busy;
  assign o_Issue_Full = i_Issue_EN && (pend_q[i_Issue_Dir] == 2'd3);

  assign inc      = i_Issue_EN && !o_Issue_Full && !(ZERO_REG && (i_Issue_Dir == '0));
  assign dec      = i_WE_MEM_WB && (pend_q[i_WB_Dir] != 2'd0);
  assign same_reg = (i_Issue_Dir == i_WB_Dir);

  // NOTE: every pend_d entry gets a default before the conditional updates, so
  // this block cannot infer latches; later assignments override earlier ones.
  always_comb begin
    for (int r = 0; r < NREG; r++)
      pend_d[r] = i_Flush ? 2'd0 : pend_q[r];
    if (!i_Flush) begin
      if (inc && !(dec && same_reg))
        pend_d[i_Issue_Dir] = pend_q[i_Issue_Dir] + 2'd1;
      if (dec && !(inc && same_reg))
        pend_d[i_WB_Dir] = pend_q[i_WB_Dir] - 2'd1;
    end
  end

  // NOTE: the register array is reset along with the scoreboard because reads
  // after reset must return zero; this keeps it in flops rather than a RAM macro.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREG; r++) begin
        regs_q[r] <= '0;
        pend_q[r] <= 2'd0;
      end
    end else begin
      for (int r = 0; r < NREG; r++)
        pend_q[r] <= pend_d[r];
      if (write_en)
        regs_q[i_WB_Dir] <= i_WB_Data;
    end
  end

endmodule
